// File: rtl/motoro3_uart_rx.sv
// UART 8N1 receiver with single-character command decode for the motor controller.
// Command outputs mimic the push-button pulses so the top level can OR them in.
module motoro3_uart_rx #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       clkI,
    input  logic       rstI,
    input  logic       uRxI,
    output logic [7:0] rxDataO,
    output logic       rxValidO,
    output logic       rxFrameErrO,
    output logic       m3startO,
    output logic       m3forceStopO,
    output logic       m3invRotateO,
    output logic       m3freqINCo,
    output logic       m3freqDECo,
    output logic       m3powerINCo,
    output logic       m3powerDECo
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bitIdx_q;
    logic [7:0]       sh_q;
    logic             sync1_q;
    logic             rxS_q;

    // Both flops reset high so reset release never looks like a start edge.
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            sync1_q <= 1'b1;
            rxS_q   <= 1'b1;
        end else begin
            sync1_q <= uRxI;
            rxS_q   <= sync1_q;
        end
    end

    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bitIdx_q     <= '0;
            sh_q         <= '0;
            rxDataO      <= '0;
            rxValidO     <= 1'b0;
            rxFrameErrO  <= 1'b0;
            m3startO     <= 1'b0;
            m3forceStopO <= 1'b0;
            m3invRotateO <= 1'b0;
            m3freqINCo   <= 1'b0;
            m3freqDECo   <= 1'b0;
            m3powerINCo  <= 1'b0;
            m3powerDECo  <= 1'b0;
        end else begin
            rxValidO     <= 1'b0;
            rxFrameErrO  <= 1'b0;
            m3startO     <= 1'b0;
            m3forceStopO <= 1'b0;
            m3freqINCo   <= 1'b0;
            m3freqDECo   <= 1'b0;
            m3powerINCo  <= 1'b0;
            m3powerDECo  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!rxS_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end

                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q    <= '0;
                        bitIdx_q <= '0;
                        state_q  <= rxS_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q <= '0;
                        sh_q  <= {rxS_q, sh_q[7:1]};
                        if (bitIdx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q <= '0;
                        if (rxS_q) begin
                            rxDataO  <= sh_q;
                            rxValidO <= 1'b1;
                            state_q  <= IDLE;
                            case (sh_q)
                                8'h53:   m3startO     <= 1'b1;
                                8'h58:   m3forceStopO <= 1'b1;
                                8'h52:   m3invRotateO <= ~m3invRotateO;
                                8'h46:   m3freqINCo   <= 1'b1;
                                8'h66:   m3freqDECo   <= 1'b1;
                                8'h50:   m3powerINCo  <= 1'b1;
                                8'h70:   m3powerDECo  <= 1'b1;
                                default: ;
                            endcase
                        end else begin
                            rxFrameErrO <= 1'b1;
                            state_q     <= BRK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                // A held-low line yields one frame error, not a stream of 0x00 bytes.
                BRK: begin
                    if (rxS_q) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motoro3_uart_rx.sv
// Scoreboarded bench for motoro3_uart_rx: CLK_DIV=16 instance for function and
// error cases, CLK_DIV=434 instance for baud-rate tolerance.
module tb_motoro3_uart_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxA = 1'b1;
    logic rxB = 1'b1;

    logic [7:0] a_data, b_data;
    logic a_valid, a_ferr, a_st, a_xs, a_inv, a_fi, a_fd, a_pi, a_pd;
    logic b_valid, b_ferr, b_st, b_xs, b_inv, b_fi, b_fd, b_pi, b_pd;

    motoro3_uart_rx #(.CLK_DIV(16)) dut (
        .clkI(clk), .rstI(rst), .uRxI(rxA),
        .rxDataO(a_data), .rxValidO(a_valid), .rxFrameErrO(a_ferr),
        .m3startO(a_st), .m3forceStopO(a_xs), .m3invRotateO(a_inv),
        .m3freqINCo(a_fi), .m3freqDECo(a_fd), .m3powerINCo(a_pi), .m3powerDECo(a_pd)
    );

    motoro3_uart_rx #(.CLK_DIV(434)) dut434 (
        .clkI(clk), .rstI(rst), .uRxI(rxB),
        .rxDataO(b_data), .rxValidO(b_valid), .rxFrameErrO(b_ferr),
        .m3startO(b_st), .m3forceStopO(b_xs), .m3invRotateO(b_inv),
        .m3freqINCo(b_fi), .m3freqDECo(b_fd), .m3powerINCo(b_pi), .m3powerDECo(b_pd)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic       ferr;
        logic       valid;
        logic [7:0] data;
        logic       st, xs, inv, fi, fd, pi, pd;
    } obs_t;

    typedef struct {
        obs_t  e;
        int    t0;
        string name;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        logic [5:0] cmd;  // {st, xs, fi, fd, pi, pd}
        logic       inv;
        string      name;
    } vec_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nEvt = 0, nValid = 0, nFerr = 0, nStart = 0;
    bit abort_tx = 1'b0;
    logic [7:0] model_data = 8'h00;
    logic       model_inv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            obs_t o;
            exp_t x;
            int   lat;
            o = {a_ferr, a_valid, a_data, a_st, a_xs, a_inv, a_fi, a_fd, a_pi, a_pd};
            if (a_valid | a_ferr | a_st | a_xs | a_fi | a_fd | a_pi | a_pd) begin
                nEvt++;
                if (a_valid) nValid++;
                if (a_ferr) nFerr++;
                if (a_st) nStart++;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event got=%h required=none", o);
                end else begin
                    x = q.pop_front();
                    if (o !== x.e) begin
                        failures++;
                        $display("FAIL %s got=%h required=%h", x.name, o, x.e);
                    end
                    if (x.t0 >= 0) begin
                        lat = cyc - x.t0;
                        checks++;
                        if (lat < 154 || lat > 158) begin
                            failures++;
                            $display("FAIL %s_latency got=%0d required=156+-2", x.name, lat);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", n, got, req);
        end
    endtask

    task automatic set_line(input bit lineB, input logic v);
        if (lineB) rxB = v;
        else rxA = v;
    endtask

    // Called at posedge+1; the start bit falls immediately.
    task automatic send(input logic [7:0] b, input logic stopb, input int per, input bit lineB);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (abort_tx) break;
            set_line(lineB, fr[i]);
            wait_cyc(per);
        end
        set_line(lineB, 1'b1);
    endtask

    task automatic expect_good(input logic [7:0] b, input logic [5:0] cmd, input logic inv,
                               input int t0, input string n);
        exp_t x;
        x.e    = {1'b0, 1'b1, b, cmd[5], cmd[4], inv, cmd[3], cmd[2], cmd[1], cmd[0]};
        x.t0   = t0;
        x.name = n;
        q.push_back(x);
        model_data = b;
        model_inv  = inv;
    endtask

    task automatic expect_ferr(input string n);
        exp_t x;
        x.e    = {1'b1, 1'b0, model_data, 1'b0, 1'b0, model_inv, 4'b0000};
        x.t0   = -1;
        x.name = n;
        q.push_back(x);
    endtask

    task automatic watch_b(output bit got, output logic [7:0] d, output bit fe);
        got = 1'b0;
        fe  = 1'b0;
        d   = 8'h00;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (b_ferr) fe = 1'b1;
            if (b_valid) begin
                got = 1'b1;
                d   = b_data;
                break;
            end
        end
    endtask

    vec_t vt[10];
    int   e0, v0, f0, s0;
    bit   got;
    bit   fe;
    logic [7:0] d;
    int   pers[2];

    initial begin
        vt[0] = '{8'h46, 6'b001000, 1'b0, "cmd_F"};
        vt[1] = '{8'h66, 6'b000100, 1'b0, "cmd_f"};
        vt[2] = '{8'h50, 6'b000010, 1'b0, "cmd_P"};
        vt[3] = '{8'h70, 6'b000001, 1'b0, "cmd_p"};
        vt[4] = '{8'h53, 6'b100000, 1'b0, "cmd_S"};
        vt[5] = '{8'h58, 6'b010000, 1'b0, "cmd_X"};
        vt[6] = '{8'h52, 6'b000000, 1'b1, "cmd_R1"};
        vt[7] = '{8'h52, 6'b000000, 1'b0, "cmd_R2"};
        vt[8] = '{8'h73, 6'b000000, 1'b0, "lower_s"};
        vt[9] = '{8'hFF, 6'b000000, 1'b0, "data_FF"};

        // Reset state
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(1);
        chk("rst_data", {24'd0, a_data}, 32'h0);
        chk("rst_pulses", {25'd0, a_valid, a_ferr, a_st, a_xs, a_fi, a_fd, a_pi, a_pd} , 32'h0);
        chk("rst_inv", {31'd0, a_inv}, 32'h0);
        wait_cyc(1000);
        chk("idle_no_events", nEvt, 0);

        // Good byte with latency
        expect_good(8'hA5, 6'b0, 1'b0, cyc, "byte_A5");
        send(8'hA5, 1'b1, 16, 1'b0);
        wait_cyc(40);

        // Command bytes back-to-back
        for (int i = 0; i < 10; i++) begin
            expect_good(vt[i].b, vt[i].cmd, vt[i].inv, -1, vt[i].name);
            send(vt[i].b, 1'b1, 16, 1'b0);
        end
        wait_cyc(40);
        chk("inv_after_RR", {31'd0, a_inv}, 32'h0);

        // Start-bit glitch
        e0 = nEvt;
        rxA = 1'b0;
        wait_cyc(4);
        rxA = 1'b1;
        wait_cyc(100);
        chk("glitch_no_event", nEvt, e0);
        expect_good(8'h5A, 6'b0, model_inv, -1, "after_glitch");
        send(8'h5A, 1'b1, 16, 1'b0);
        wait_cyc(40);

        // Stop bit low
        expect_ferr("stop_low");
        send(8'h33, 1'b0, 16, 1'b0);
        wait_cyc(40);
        chk("data_kept", {24'd0, a_data}, {24'd0, model_data});

        // Held-low break
        v0 = nValid;
        f0 = nFerr;
        expect_ferr("break");
        rxA = 1'b0;
        wait_cyc(500);
        rxA = 1'b1;
        wait_cyc(60);
        chk("break_ferr_count", nFerr - f0, 1);
        chk("break_no_valid", nValid - v0, 0);

        // Reset during data bit 4 of 'S'
        s0 = nStart;
        fork
            send(8'h53, 1'b1, 16, 1'b0);
            begin
                wait_cyc(16 * 5 + 8);
                rst = 1'b1;
                abort_tx = 1'b1;
            end
        join
        wait_cyc(3);
        rst = 1'b0;
        abort_tx = 1'b0;
        model_data = 8'h00;
        model_inv = 1'b0;
        wait_cyc(200);
        chk("midrst_no_start", nStart - s0, 0);
        chk("midrst_data_cleared", {24'd0, a_data}, 32'h0);
        expect_good(8'h53, 6'b100000, 1'b0, -1, "post_rst_S");
        send(8'h53, 1'b1, 16, 1'b0);
        wait_cyc(40);
        chk("post_rst_one_start", nStart - s0, 1);

        // Baud tolerance on the CLK_DIV=434 instance
        pers[0] = 421;
        pers[1] = 447;
        for (int i = 0; i < 2; i++) begin
            fork
                send(8'h3C, 1'b1, pers[i], 1'b1);
                watch_b(got, d, fe);
            join
            wait_cyc(1);
            chk($sformatf("rate%0d_valid", pers[i]), {31'd0, got}, 32'd1);
            chk($sformatf("rate%0d_data", pers[i]), {24'd0, d}, 32'h3C);
            chk($sformatf("rate%0d_no_ferr", pers[i]), {31'd0, fe}, 32'd0);
            wait_cyc(500);
        end

        // Drain
        for (int c = 0; c < 2000 && q.size() != 0; c++) wait_cyc(1);
        chk("scoreboard_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motoro3_uart_rx.md
# motoro3_uart_rx

UART 8N1 receiver and command decoder for the three-phase motor controller. It samples the serial line `uRxI` in the `clkI` domain and delivers each received byte with a one-cycle valid strobe. It also translates single-character commands into one-cycle control pulses of the same kind as the motor push-button inputs (start, force-stop, invert, frequency and power inc/dec). It sits between the board's UART RX pin and `motoro3_top`, alongside the existing push-button path; the top level ORs its pulses with the button inputs.

## Interface
- `CLK_DIV`, default 434: `clkI` cycles per bit (50 MHz / 115200). Must be ≥ 8; even values are preferred.
- `clkI`  in  1  system clock, 50 MHz.
- `rstI`  in  1  reset, asynchronous, active-high.
- `uRxI`  in  1  serial line; idles high; asynchronous to `clkI`.
- `rxDataO`  out  8  last good byte; holds its value until the next good byte.
- `rxValidO`  out  1  one-cycle pulse when `rxDataO` is updated.
- `rxFrameErrO`  out  1  one-cycle pulse when the stop bit is sampled low.
- `m3startO`  out  1  one-cycle pulse on byte 0x53 'S'.
- `m3forceStopO`  out  1  one-cycle pulse on byte 0x58 'X'.
- `m3invRotateO`  out  1  level output; toggles on byte 0x52 'R'.
- `m3freqINCo` / `m3freqDECo`  out  1 each  one-cycle pulse on 0x46 'F' / 0x66 'f'.
- `m3powerINCo` / `m3powerDECo`  out  1 each  one-cycle pulse on 0x50 'P' / 0x70 'p'.

## Operation
- **Input synchronizer:** `uRxI` passes through a 2-flop synchronizer. Both flops reset to 1. All logic below uses the synchronized value `rxS`.
- **Bit counter:** `cnt` is ceil(log2(CLK_DIV)) bits wide. **Bit index:** `bitIdx` is 3 bits. **Shift register:** `sh` is 8 bits.
- **FSM states:** IDLE, START, DATA, STOP, BRK.
- **IDLE:** when `rxS`=0, go to START with `cnt`=0.
- **START:** at `cnt`=CLK_DIV/2−1, sample `rxS`.
  - If `rxS`=1, treat it as a glitch and return to IDLE; no output.
  - If `rxS`=0, go to DATA with `cnt`=0 and `bitIdx`=0.
- **DATA:** at `cnt`=CLK_DIV−1, sample the bit mid-cell and apply `sh` <= {`rxS`, `sh`[7:1]} (LSB first), then reset `cnt`.
  - After `bitIdx`=7, go to STOP; otherwise increment `bitIdx`.
- **STOP:** at `cnt`=CLK_DIV−1, sample `rxS`.
  - If `rxS`=1: register `rxDataO`<=`sh`, pulse `rxValidO`, decode the command, and go to IDLE.
  - If `rxS`=0: pulse `rxFrameErrO`; `rxDataO` and the command outputs are unchanged; go to BRK.
- **BRK:** wait until `rxS`=1, then go to IDLE. A held-low break line therefore produces exactly one frame error and is not re-parsed as a stream of 0x00 bytes.
- **Command decode:** registered, using the same byte that produced `rxValidO`. A command pulse is asserted in the same cycle as `rxValidO`.
  - Bytes outside the command set produce `rxValidO` only.
  - Matching is case-sensitive.
- **Reset values** (all outputs are registered): `rxDataO`=0x00, every pulse output=0, `m3invRotateO`=0, state=IDLE, `cnt`=0, `bitIdx`=0, `sh`=0.
- **Reset mid-frame:** the frame is abandoned and no pulse is produced. After release, the block waits in IDLE for the next falling edge. A partial frame still on the line may be misframed; this is accepted.
- **Back-to-back frames:** a new start bit is accepted starting in the first IDLE cycle after the STOP sample. No idle gap beyond the stop bit is required.
- The block has no flow control and no buffering: each byte is presented for one cycle only.

## Timing
- **Latency:** measured from the `uRxI` falling edge of the start bit to `rxValidO` high, nominally 2 (synchronizer) + 1 + CLK_DIV/2 + 9·CLK_DIV + 1 cycles. The bench tolerance is ±2 cycles.
- **Sample point:** each data bit is sampled (CLK_DIV/2 + k·CLK_DIV) cycles after the synchronized start edge, for k=1..8. The stop bit is sampled at k=9.
- **Baud mismatch:** the receiver tolerates a ±3% rate mismatch between sender and `CLK_DIV`.
- **Pulse width:** all pulses are exactly one `clkI` cycle. At most one command output changes per frame.

## Test plan
Scenarios 1–5 use CLK_DIV=16.
1. **Reset state:** assert `rstI` with `uRxI`=1, then release. All outputs are 0 and `rxDataO`=0x00; with the line idle for 1000 cycles, no pulse occurs.
2. **Good byte:** send frame 0xA5. `rxValidO` pulses once, at 2+1+8+144+1 = 156 ±2 cycles after the start edge, with `rxDataO`=0xA5; no command pulse; `rxFrameErrO`=0.
3. **Command bytes:** send 'F', 'f', 'P', 'p', 'S', 'X', 'R', 'R' back-to-back. Each byte produces its matching pulse exactly once, coincident with `rxValidO`. `m3invRotateO` goes 0→1→0.
4. **Errors:**
   - A 4-cycle low glitch on `uRxI` produces no output, and the FSM returns to IDLE.
   - A frame with stop=0 pulses `rxFrameErrO` once; `rxDataO` keeps its prior value.
   - Holding the line low for 500 cycles produces exactly one `rxFrameErrO` and no `rxValidO`.
5. **Reset mid-frame:** assert `rstI` during data bit 4 of 0x53. No `m3startO` pulse occurs. Idle the line, then send 0x53; exactly one `m3startO` pulse follows.
6. **Rate tolerance:** with CLK_DIV=434, send 0x3C at bit periods of 421 and 447 cycles. Both frames are received correctly.
